// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes (matching the
// core's decode), opcode constants, the request struct and immediate range helper.
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    IT_U = 3'd0,
    IT_J = 3'd1,
    IT_I = 3'd2,
    IT_S = 3'd3,
    IT_B = 3'd4
  } inst_type_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  typedef struct packed {
    logic [2:0]  itype;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } enc_req_t;

  // True when v[31:msb] are all equal, i.e. v is representable as a signed (msb+1)-bit value.
  function automatic logic imm_fits(input logic [31:0] v, input int unsigned msb);
    logic [31:0] t;
    t = 32'($signed(v) >>> msb);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_imm_packer.sv
// Combinational RV32I field packer: scatters the immediate per format and flags
// immediates that do not survive the round trip through decode.
module inst_encoder_imm_packer
  import inst_encoder_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] inst,
  output logic        err
);

  logic [31:0] i;
  assign i = req.imm;

  always_comb begin
    inst = '0;
    err  = 1'b0;
    case (req.itype)
      IT_U: begin
        inst = {i[31:12], req.rd, req.opcode};
        err  = |i[11:0];
      end
      IT_J: begin
        inst = {i[20], i[10:1], i[11], i[19:12], req.rd, req.opcode};
        err  = !imm_fits(i, 20) || i[0];
      end
      IT_S: begin
        inst = {i[11:5], req.rs2, req.rs1, req.funct3, i[4:0], req.opcode};
        err  = !imm_fits(i, 11);
      end
      IT_B: begin
        inst = {i[12], i[10:5], req.rs2, req.rs1, req.funct3, i[4:1], i[11], req.opcode};
        err  = !imm_fits(i, 12) || i[0];
      end
      default: begin
        // Illegal type codes still produce an I-format word so the stream never stalls.
        inst = {i[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        err  = (req.itype != IT_I) || !imm_fits(i, 11);
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready instruction encoder: S1 captures the request, S2 holds the
// packed word; output words carry an incrementing instruction-memory address.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        inst_type,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  enc_req_t        in_req, s1_req;
  logic            s1_adv;
  logic            out_fire;
  logic [31:0]     pk_inst;
  logic            pk_err;

  assign in_req = '{itype: inst_type, opcode: opcode, rd: rd, funct3: funct3,
                    rs1: rs1, rs2: rs2, imm: imm};

  assign s1_adv    = !vld_pipe[2] || out_ready;
  assign in_ready  = !vld_pipe[1] || s1_adv;
  assign out_valid = vld_pipe[2];
  assign out_fire  = vld_pipe[2] && out_ready;

  inst_encoder_imm_packer u_packer (
    .req  (s1_req),
    .inst (pk_inst),
    .err  (pk_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_req   <= '0;
    end else if (in_ready) begin
      vld_pipe[1] <= in_valid;
      if (in_valid) s1_req <= in_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[2] <= 1'b0;
      out_inst    <= '0;
      out_err     <= 1'b0;
    end else if (s1_adv) begin
      vld_pipe[2] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        out_inst <= pk_inst;
        out_err  <= pk_err;
      end
    end
  end

  // Address and error count follow words leaving the block, not words entering it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_addr  <= BASE_ADDR;
      err_count <= '0;
    end else if (out_fire) begin
      out_addr <= out_addr + ADDR_W'(ADDR_STEP);
      if (out_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed encodings, error cases, throughput,
// stall stability, random immediate round-trip through an RV32I decoder, and reset.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  inst_type;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .ADDR_STEP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_type(inst_type), .opcode(opcode), .rd(rd), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  typedef struct {
    logic [31:0] inst;
    bit          known;
    logic [2:0]  typ;
    logic [6:0]  op;
    logic [31:0] imm;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   out_cnt = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] decode_imm(input logic [31:0] w, input logic [2:0] t);
    case (t)
      3'd0:    return {w[31:12], 12'h000};
      3'd1:    return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      3'd3:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd4:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {{20{w[31]}}, w[31:20]};
    endcase
  endfunction

  // Output monitor: one scoreboard entry per output handshake.
  always @(negedge clk) begin
    if (rst) begin
      out_cnt = 0;
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_empty", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("addr", 64'(out_addr), 64'(32'(out_cnt * 4)));
        check("err", 64'(out_err), 64'(e.err));
        check("opcode", 64'(out_inst[6:0]), 64'(e.op));
        if (e.known) check("inst", 64'(out_inst), 64'(e.inst));
        if (!e.err) check("roundtrip", 64'(decode_imm(out_inst, e.typ)), 64'(e.imm));
      end
      out_cnt = out_cnt + 1;
    end
  end

  task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [4:0] d,
                      input logic [2:0] f3, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input bit known, input logic [31:0] exp_inst,
                      input logic exp_err);
    bit ok = 0;
    exp_t x;
    in_valid = 1'b1; inst_type = t; opcode = op; rd = d; funct3 = f3;
    rs1 = s1; rs2 = s2; imm = im;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      x.inst = exp_inst; x.known = known; x.typ = t; x.op = op; x.imm = im; x.err = exp_err;
      sb.push_back(x);
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 200 && sb.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    int        bt[9];
    int        bi[9];
    logic [31:0] r, im, hold_inst, hold_addr;
    logic [2:0]  t;
    time         t0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    inst_type = '0; opcode = '0; rd = '0; funct3 = '0; rs1 = '0; rs2 = '0; imm = '0;
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_inst", 64'(out_inst), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // 1: addi x1,x0,5 and its latency
    send(3'd2, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd5, 1, 32'h00500093, 1'b0);
    check("lat_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_2cyc", 64'(out_valid), 64'd1);
    wait_drain();

    // 2: U / S / J directed words
    send(3'd0, 7'h37, 5'd2, 3'd0, 5'd0, 5'd0, 32'h12345000, 1, 32'h12345137, 1'b0);
    send(3'd3, 7'h23, 5'd0, 3'd2, 5'd2, 5'd5, 32'hFFFFFFFC, 1, 32'hFE512E23, 1'b0);
    send(3'd1, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'd8, 1, 32'h008000EF, 1'b0);
    wait_drain();

    // 3: error cases are emitted and counted
    send(3'd2, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'h800, 0, 32'h0, 1'b1);
    send(3'd4, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'd3, 0, 32'h0, 1'b1);
    send(3'd0, 7'h37, 5'd3, 3'd0, 5'd0, 5'd0, 32'h1001, 0, 32'h0, 1'b1);
    send(3'd6, 7'h13, 5'd4, 3'd0, 5'd0, 5'd0, 32'h0, 0, 32'h0, 1'b1);
    wait_drain();
    check("err_count4", 64'(err_count), 64'd4);

    // 4: back-to-back burst from address 0, then a stall
    do_reset();
    t0 = $time;
    for (int k = 0; k < 8; k++)
      send(3'd2, 7'h13, 5'(k), 3'd0, 5'd0, 5'd0, 32'(k), 1,
           {20'(k), 5'd0, 3'd0, 5'(k), 7'h13}, 1'b0);
    check("b2b_in_cycles", 64'(($time - t0) / 10), 64'd8);
    check("b2b_pending", 64'(sb.size()), 64'd2);
    wait_drain();
    check("b2b_addr_next", 64'(out_addr), 64'd32);

    out_ready = 1'b0;
    send(3'd2, 7'h13, 5'd9, 3'd0, 5'd0, 5'd0, 32'd100, 1, 32'h06400493, 1'b0);
    send(3'd2, 7'h13, 5'd10, 3'd0, 5'd0, 5'd0, 32'd101, 1, 32'h06500513, 1'b0);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    hold_inst = out_inst; hold_addr = out_addr;
    check("stall_valid0", 64'(out_valid), 64'd1);
    check("stall_inst0", 64'(out_inst), 64'h06400493);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_inst", 64'(out_inst), 64'(hold_inst));
      check("stall_addr", 64'(out_addr), 64'(hold_addr));
      check("stall_in_ready_hold", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    wait_drain();

    // 5: boundary then random legal immediates, decoded back by the monitor
    bt = '{2, 2, 3, 3, 4, 4, 1, 1, 0};
    bi = '{-2048, 2047, -2048, 2047, -4096, 4094, -1048576, 1048574, 32'hFFFFF000};
    for (int k = 0; k < 10000; k++) begin
      r = $urandom;
      if (k < 9) begin
        t = 3'(bt[k]); im = 32'(bi[k]);
      end else begin
        t = 3'($urandom_range(0, 4));
        case (t)
          3'd0:    im = {r[31:12], 12'h000};
          3'd1:    im = {{11{r[20]}}, r[20:1], 1'b0};
          3'd4:    im = {{19{r[12]}}, r[12:1], 1'b0};
          default: im = {{20{r[11]}}, r[11:0]};
        endcase
      end
      send(t, 7'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
           im, 0, 32'h0, 1'b0);
    end
    wait_drain();

    // 6: reset with both stages full
    send(3'd0, 7'h37, 5'd1, 3'd0, 5'd0, 5'd0, 32'h1, 0, 32'h0, 1'b1);
    wait_drain();
    check("pre_rst_err_count", 64'(err_count), 64'd1);
    out_ready = 1'b0;
    send(3'd2, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd7, 1, 32'h00700093, 1'b0);
    send(3'd2, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 32'd8, 1, 32'h00800113, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_addr", 64'(out_addr), 64'd0);
    check("mid_rst_err_count", 64'(err_count), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(3'd2, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 32'd9, 1, 32'h00900193, 1'b0);
    wait_drain();
    check("post_rst_count", 64'(out_cnt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
